// File: rtl/mpu_pkg.sv
// Shared types and defaults for the MPU ID allocation logic.
// Holds the free-list FSM encoding and default ID sizing.
package mpu_pkg;

  localparam int unsigned NUM_IDS_DEF = 16;
  localparam int unsigned ID_W_DEF = $clog2(NUM_IDS_DEF);

  typedef logic [ID_W_DEF-1:0] id_t;
  typedef logic [ID_W_DEF:0] id_cnt_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fl_state_t;

endpackage

// File: rtl/id_ring_buffer.sv
// Register-based circular ID store with head/tail pointers.
// Pointers wrap by natural overflow; clr rewinds both to zero.
module id_ring_buffer #(
  parameter int NUM_IDS = 16,
  parameter int ID_W = $clog2(NUM_IDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_id,
  input  logic            rd_en,
  output logic [ID_W-1:0] rd_id
);

  logic [ID_W-1:0] mem [NUM_IDS];
  logic [ID_W-1:0] head;
  logic [ID_W-1:0] tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else if (clr) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (wr_en) tail <= tail + 1'b1;
      if (rd_en) head <= head + 1'b1;
    end
  end

  // Contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[tail] <= wr_id;
  end

  assign rd_id = mem[head];

endmodule

// File: rtl/id_free_list.sv
// Free list of NUM_IDS IDs: init fill, alloc/free handshakes,
// ownership tracking and sticky double-free detection.
module id_free_list
  import mpu_pkg::*;
#(
  parameter int NUM_IDS = NUM_IDS_DEF,
  parameter int LOW_WATER = 2,
  localparam int ID_W = $clog2(NUM_IDS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  output logic            alloc_valid,
  input  logic            alloc_ready,
  output logic [ID_W-1:0] alloc_id,
  input  logic            free_valid,
  output logic            free_ready,
  input  logic [ID_W-1:0] free_id,
  output logic [ID_W:0]   count,
  output logic            empty,
  output logic            full,
  output logic            low_water,
  output logic            init_done,
  output logic            err_double_free,
  input  logic            err_clear
);

  fl_state_t state;
  logic [ID_W-1:0] init_ptr;
  logic [ID_W:0] count_q;
  logic [NUM_IDS-1:0] owned;
  logic err_q;

  logic in_run;
  logic in_init;
  logic pop;
  logic free_ok;
  logic dbl_free;
  logic rb_wr;
  logic rb_rd;
  logic [ID_W-1:0] rb_wr_id;
  logic [ID_W:0] inc;
  logic [ID_W:0] dec;

  assign in_run = (state == ST_RUN);
  assign in_init = (state == ST_INIT);
  assign pop = in_run && (count_q != '0) && alloc_ready;
  assign free_ok = in_run && free_valid && owned[free_id];
  assign dbl_free = in_run && free_valid && !owned[free_id];

  assign rb_wr = !flush && (in_init || free_ok);
  assign rb_rd = !flush && pop;
  assign rb_wr_id = in_init ? init_ptr : free_id;
  assign inc = {{ID_W{1'b0}}, free_ok};
  assign dec = {{ID_W{1'b0}}, pop};

  id_ring_buffer #(
    .NUM_IDS(NUM_IDS),
    .ID_W(ID_W)
  ) u_ring (
    .clk(clk),
    .rst_n(rst_n),
    .clr(flush),
    .wr_en(rb_wr),
    .wr_id(rb_wr_id),
    .rd_en(rb_rd),
    .rd_id(alloc_id)
  );

  // owned=1 means the ID is outside the list (held by a consumer).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_INIT;
      init_ptr <= '0;
      count_q <= '0;
      owned <= '1;
    end else if (flush) begin
      state <= ST_INIT;
      init_ptr <= '0;
      count_q <= '0;
      owned <= '1;
    end else begin
      unique case (state)
        ST_INIT: begin
          owned[init_ptr] <= 1'b0;
          init_ptr <= init_ptr + 1'b1;
          count_q <= count_q + 1'b1;
          if (init_ptr == ID_W'(NUM_IDS - 1)) state <= ST_RUN;
        end
        ST_RUN: begin
          if (pop) owned[alloc_id] <= 1'b1;
          if (free_ok) owned[free_id] <= 1'b0;
          count_q <= count_q + inc - dec;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (dbl_free) err_q <= 1'b1;
    else if (err_clear) err_q <= 1'b0;
  end

  assign count = count_q;
  assign alloc_valid = in_run && (count_q != '0);
  assign free_ready = in_run;
  assign init_done = in_run;
  assign empty = (count_q == '0);
  assign full = (count_q == (ID_W+1)'(NUM_IDS));
  assign low_water = (count_q <= (ID_W+1)'(LOW_WATER));
  assign err_double_free = err_q;

endmodule

// File: tb/tb_id_free_list.sv
// Bench for id_free_list (NUM_IDS=8, LOW_WATER=2): queue model
// checked every cycle plus directed literal expectations.
module tb_id_free_list;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic alloc_valid;
  logic alloc_ready = 1'b0;
  logic [2:0] alloc_id;
  logic free_valid = 1'b0;
  logic free_ready;
  logic [2:0] free_id = '0;
  logic [3:0] count;
  logic empty;
  logic full;
  logic low_water;
  logic init_done;
  logic err_double_free;
  logic err_clear = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc;

  always #5 clk = ~clk;

  id_free_list #(
    .NUM_IDS(8),
    .LOW_WATER(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .alloc_valid(alloc_valid),
    .alloc_ready(alloc_ready),
    .alloc_id(alloc_id),
    .free_valid(free_valid),
    .free_ready(free_ready),
    .free_id(free_id),
    .count(count),
    .empty(empty),
    .full(full),
    .low_water(low_water),
    .init_done(init_done),
    .err_double_free(err_double_free),
    .err_clear(err_clear)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Model: the free list is a plain FIFO queue of IDs.
  int q[$];
  bit mown [8] = '{default: 1'b1};
  bit minit = 1'b1;
  int icnt = 0;
  bit merr = 1'b0;
  bit mdbl;
  int mpop;
  int n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mown = '{default: 1'b1};
      minit = 1'b1;
      icnt = 0;
      merr = 1'b0;
    end else begin
      mdbl = !minit && free_valid && !mown[free_id];
      if (mdbl) merr = 1'b1;
      else if (err_clear) merr = 1'b0;
      if (flush) begin
        q.delete();
        mown = '{default: 1'b1};
        minit = 1'b1;
        icnt = 0;
      end else if (minit) begin
        q.push_back(icnt);
        mown[icnt] = 1'b0;
        icnt++;
        if (icnt == 8) minit = 1'b0;
      end else begin
        if (q.size() > 0 && alloc_ready) begin
          mpop = q.pop_front();
          mown[mpop] = 1'b1;
        end
        if (free_valid && !mdbl) begin
          q.push_back(int'(free_id));
          mown[free_id] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    n = q.size();
    chk("init_done", int'(init_done), int'(!minit));
    chk("free_ready", int'(free_ready), int'(!minit));
    chk("alloc_valid", int'(alloc_valid), int'(!minit && n > 0));
    if (!minit && n > 0) chk("alloc_id", int'(alloc_id), q[0]);
    chk("count", int'(count), n);
    chk("empty", int'(empty), int'(n == 0));
    chk("full", int'(full), int'(n == 8));
    chk("low_water", int'(low_water), int'(n <= 2));
    chk("err", int'(err_double_free), int'(merr));
  end

  initial begin
    repeat (3) step();
    chk("rst_alloc_valid", int'(alloc_valid), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_low_water", int'(low_water), 1);
    chk("rst_init_done", int'(init_done), 0);
    rst_n = 1'b1;
    cyc = 0;
    while (!init_done && cyc < 20) begin
      step();
      cyc++;
    end
    chk("init_latency", cyc, 8);
    chk("init_count", int'(count), 8);
    chk("init_full", int'(full), 1);
    chk("init_alloc_id", int'(alloc_id), 0);

    alloc_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("pop_order", int'(alloc_id), i);
      if (i == 5) chk("low_water_c3", int'(low_water), 0);
      if (i == 6) chk("low_water_c2", int'(low_water), 1);
      step();
    end
    alloc_ready = 1'b0;
    chk("drain_empty", int'(empty), 1);
    chk("drain_valid", int'(alloc_valid), 0);

    free_valid = 1'b1;
    free_id = 3'd5;
    step();
    free_id = 3'd3;
    step();
    free_valid = 1'b0;
    chk("refill_count", int'(count), 2);
    alloc_ready = 1'b1;
    chk("realloc_5", int'(alloc_id), 5);
    step();
    chk("realloc_3", int'(alloc_id), 3);
    step();
    alloc_ready = 1'b0;
    chk("realloc_count", int'(count), 0);

    for (int i = 4; i < 8; i++) begin
      free_valid = 1'b1;
      free_id = 3'(i);
      step();
    end
    free_valid = 1'b0;
    chk("four_count", int'(count), 4);
    alloc_ready = 1'b1;
    free_valid = 1'b1;
    free_id = 3'd2;
    step();
    free_valid = 1'b0;
    alloc_ready = 1'b0;
    chk("same_cyc_count", int'(count), 4);
    chk("same_cyc_err", int'(err_double_free), 0);
    chk("same_cyc_head", int'(alloc_id), 5);
    alloc_ready = 1'b1;
    repeat (3) step();
    alloc_ready = 1'b0;
    chk("tail_id2", int'(alloc_id), 2);
    chk("tail_count", int'(count), 1);

    free_valid = 1'b1;
    free_id = 3'd6;
    step();
    step();
    free_valid = 1'b0;
    chk("dbl_count", int'(count), 2);
    chk("dbl_err", int'(err_double_free), 1);
    step();
    chk("dbl_sticky", int'(err_double_free), 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("err_cleared", int'(err_double_free), 0);
    free_valid = 1'b1;
    err_clear = 1'b1;
    step();
    free_valid = 1'b0;
    err_clear = 1'b0;
    chk("err_wins", int'(err_double_free), 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;

    alloc_ready = 1'b1;
    free_valid = 1'b1;
    free_id = 3'd2;
    step();
    alloc_ready = 1'b0;
    free_valid = 1'b0;
    chk("pop_free_err", int'(err_double_free), 1);
    chk("pop_free_count", int'(count), 1);
    chk("pop_free_head", int'(alloc_id), 6);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;

    free_valid = 1'b1;
    free_id = 3'd0;
    step();
    free_id = 3'd1;
    step();
    free_valid = 1'b0;
    chk("pre_flush_count", int'(count), 3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    cyc = 0;
    while (!init_done && cyc < 20) begin
      cyc++;
      step();
    end
    chk("flush_init_cycles", cyc, 8);
    chk("flush_count", int'(count), 8);
    chk("flush_alloc_id", int'(alloc_id), 0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_free_list.md
ID_FREE_LIST -- requirements
Module: id_free_list

Interface
REQ-001 SHALL have parameter NUM_IDS, default 16, number of managed IDs (power of two, 2..1024).
REQ-002 SHALL have parameter LOW_WATER, default 2, threshold for low_water flag.
REQ-003 SHALL have localparam ID_W = $clog2(NUM_IDS).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  return every ID to the free list via re-initialisation.
REQ-007 alloc_valid  output  1  an ID is available for allocation.
REQ-008 alloc_ready  input  1  consumer takes alloc_id this cycle.
REQ-009 alloc_id  output  ID_W  ID at list head.
REQ-010 free_valid  input  1  free_id is being returned.
REQ-011 free_ready  output  1  list accepts frees.
REQ-012 free_id  input  ID_W  ID being returned.
REQ-013 count  output  ID_W+1  number of free IDs held.
REQ-014 empty, full, low_water  output  1 each  count==0, count==NUM_IDS, count<=LOW_WATER.
REQ-015 init_done  output  1  high in RUN state.
REQ-016 err_double_free  output  1  sticky; set by rejected free.
REQ-017 err_clear  input  1  clears err_double_free.

Function
REQ-018 SHALL implement two-state FSM: INIT, RUN.
REQ-019 INIT: one write per cycle, mem[init_ptr]=init_ptr, tail and count increment; after NUM_IDS writes -> RUN (tail wrapped to 0, count=NUM_IDS).
REQ-020 alloc_valid = RUN && count>0; alloc_id = mem[head], combinational from registers.
REQ-021 free_ready = RUN.
REQ-022 Pop when alloc_valid && alloc_ready: head+1 (mod NUM_IDS), count-1, owned[alloc_id]=1.
REQ-023 Push when free_valid && free_ready && owned[free_id]: mem[tail]=free_id, tail+1 (mod NUM_IDS), owned[free_id]=0, count+1.
REQ-024 Free with owned[free_id]==0 SHALL be dropped, list unchanged, err_double_free set next cycle.
REQ-025 Pop and accepted push in the same cycle SHALL both occur; count unchanged.
REQ-026 Free of the ID being popped the same cycle SHALL be treated as double-free (owned sampled pre-edge).
REQ-027 Push cannot overflow: owned tracking guarantees count<=NUM_IDS; full with free_valid is always double-free.
REQ-028 Pointers SHALL wrap modulo NUM_IDS by natural ID_W overflow.
REQ-029 flush (any state) SHALL next cycle enter INIT with head=tail=count=init_ptr=0, owned all 1; pending pop/push that cycle ignored.
REQ-030 err_clear and a new error same cycle: error wins.

Reset
REQ-031 Reset SHALL force INIT, head=tail=count=init_ptr=0, owned all 1, err_double_free=0.
REQ-032 Outputs under reset: alloc_valid=0, free_ready=0, init_done=0, empty=1, full=0, low_water=1; mem contents don't-care.

Structure
REQ-033 ID_W-derived types and NUM_IDS default SHALL live in shared package mpu_pkg.
REQ-034 Storage plus head/tail pointers SHALL be sub-module id_ring_buffer; FSM, owned bitmap, errors in top.
REQ-035 mem and owned SHALL be registers, no RAM inference.

Verification (NUM_IDS=8, LOW_WATER=2)
REQ-036 Release reset -> init_done rises after 8 cycles; count=8, full=1, alloc_id=0.
REQ-037 Pop 8 with alloc_ready held -> IDs 0..7 in order, then empty=1, alloc_valid=0, low_water set at count=2.
REQ-038 Free 5 then 3 after emptying -> alloc returns 5 then 3; count 2 -> 0.
REQ-039 Pop and free ID 2 same cycle with count=4 -> count stays 4, ID 2 at tail.
REQ-040 Free ID 6 while still in list -> dropped, count unchanged, err_double_free=1 until err_clear.
REQ-041 flush with count=3 -> init_done=0 for 8 cycles, then count=8, alloc_id=0.
